ppi_bus_sequencer: RTL and testbench

- Bus-master controller that drives the PPI's host-side interface (CS, RD, WR, A[1:0], PD) from a simple valid/ready request channel.
- Converts single-cycle requests into properly timed PPI read/write cycles with programmable setup, strobe and hold lengths.
- Keeps a shadow copy of the last mode-set control word and flags direction-violating accesses.
- Sits between the system-side host logic and the PPI top level; it is the only master of the PPI bus.

---
 rtl/ppi_pkg.sv | 43 ++++
 rtl/ppi_bus_sequencer_if.sv | 34 +++
 rtl/ppi_access_check.sv | 46 ++++
 rtl/ppi_bus_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_ppi_bus_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppi_pkg.sv
// ---------------------------------------------------------------------------
// ppi_pkg
// Shared definitions for the PPI bus sequencer:
//   - sequencer FSM state encoding
//   - PPI register addresses (port A/B/C, control)
//   - control-word bit positions used by the direction checker
//   - control word assumed after reset (mode set, all ports input)
//   - small helper for sizing the phase counter
// ---------------------------------------------------------------------------
package ppi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_RESP   = 3'd4
   } ppi_state_t;

   localparam logic [1:0] PPI_PORT_A    = 2'd0;
   localparam logic [1:0] PPI_PORT_B    = 2'd1;
   localparam logic [1:0] PPI_PORT_C    = 2'd2;
   localparam logic [1:0] PPI_PORT_CTRL = 2'd3;

   // Control-word bit positions (1 = input for the direction bits)
   localparam int MODE_SET = 7;
   localparam int A_DIR    = 4;
   localparam int CU_DIR   = 3;
   localparam int B_DIR    = 1;
   localparam int CL_DIR   = 0;

   localparam logic [7:0] CW_RESET_DEFAULT = 8'h9B;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/ppi_bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// ppi_bus_sequencer_if
// Host-side request/response channel of the PPI bus sequencer.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_write           : 1 = write, 0 = read
//   req_addr            : PPI register (A, B, C, control)
//   req_data            : write data
//   rsp_valid           : one-cycle completion pulse
//   rsp_data            : read data (0 for writes)
//   rsp_err             : direction / illegal-access flag, valid with rsp_valid
// Modports: master = host logic, slave = sequencer.
// ---------------------------------------------------------------------------
interface ppi_bus_sequencer_if;

   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [1:0] req_addr;
   logic [7:0] req_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/ppi_access_check.sv
// ---------------------------------------------------------------------------
// ppi_access_check
// Combinational access checker for a PPI request.
//   addr, write, data : the request being accepted
//   shadow            : current shadow copy of the mode-set control word
//   err               : access goes against the configured port direction,
//                       or is a read of the write-only control register
//   shadow_load       : request is a mode-set write (control reg, bit 7 = 1)
// A BSR write (control reg, bit 7 = 0) is legal and leaves the shadow alone.
// ---------------------------------------------------------------------------
module ppi_access_check
   import ppi_pkg::*;
(
   input  logic [1:0] addr,
   input  logic       write,
   input  logic [7:0] data,
   input  logic [7:0] shadow,
   output logic       err,
   output logic       shadow_load
);

   always_comb begin
      err = 1'b0;
      if (write) begin
         unique case (addr)
            PPI_PORT_A:    err = shadow[A_DIR];
            PPI_PORT_B:    err = shadow[B_DIR];
            // Port C is only wrong to write when both halves are inputs
            PPI_PORT_C:    err = shadow[CU_DIR] & shadow[CL_DIR];
            PPI_PORT_CTRL: err = 1'b0;
            default:       err = 1'b0;
         endcase
      end else begin
         unique case (addr)
            PPI_PORT_A:    err = ~shadow[A_DIR];
            PPI_PORT_B:    err = ~shadow[B_DIR];
            PPI_PORT_C:    err = 1'b0;
            PPI_PORT_CTRL: err = 1'b1;
            default:       err = 1'b0;
         endcase
      end
   end

   assign shadow_load = write && (addr == PPI_PORT_CTRL) && data[MODE_SET];

endmodule

// File: rtl/ppi_bus_sequencer.sv
// ---------------------------------------------------------------------------
// ppi_bus_sequencer
// Sole bus master of the PPI host interface. Turns single-cycle requests
// into timed PPI cycles: SETUP (CS/A/data valid), STROBE (RD or WR low),
// HOLD (strobe released, CS/A/data kept), then a one-cycle RESP.
// Ports:
//   CLK, RST     : clock, asynchronous active-high reset
//   host         : request/response channel (slave side)
//   busy         : transaction in progress (every state but IDLE)
//   CS, RD, WR   : PPI chip select / read / write strobes, active low
//   A            : PPI register address
//   PD_out/PD_oe : write data and its tri-state enable
//   PD_in        : data read back from the PPI
//   mode_shadow  : last mode-set control word written
// All bus outputs are registered; their next values are derived from the
// next FSM state so they line up with the state they belong to.
// ---------------------------------------------------------------------------
module ppi_bus_sequencer
   import ppi_pkg::*;
#(
   parameter int unsigned T_SETUP  = 1,
   parameter int unsigned T_STROBE = 2,
   parameter int unsigned T_HOLD   = 1,
   parameter logic [7:0]  CW_RESET = CW_RESET_DEFAULT
) (
   input  logic                CLK,
   input  logic                RST,
   ppi_bus_sequencer_if.slave  host,
   output logic                busy,
   output logic                CS,
   output logic                RD,
   output logic                WR,
   output logic [1:0]          A,
   output logic [7:0]          PD_out,
   output logic                PD_oe,
   input  logic [7:0]          PD_in,
   output logic [7:0]          mode_shadow
);

   // Counter holds "cycles remaining - 1", so the largest value is max-1
   localparam int unsigned CNT_MAX = max3(T_SETUP, T_STROBE, T_HOLD);
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(T_STROBE - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(T_HOLD - 1);

   ppi_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_wr_q, is_wr_d;
   logic [1:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic             err_q, err_d;
   logic             load_q, load_d;
   logic [7:0]       rdata_q, rdata_d;
   logic [7:0]       shadow_q, shadow_d;

   logic             cs_q, cs_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic [1:0]       a_q, a_d;
   logic [7:0]       pd_out_q, pd_out_d;
   logic             pd_oe_q, pd_oe_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;

   logic             chk_err;
   logic             chk_load;
   logic             bus_d;
   logic             strobe_d;

   // Evaluated against the shadow as it stands when the request is accepted
   ppi_access_check u_check (
      .addr        (host.req_addr),
      .write       (host.req_write),
      .data        (host.req_data),
      .shadow      (shadow_q),
      .err         (chk_err),
      .shadow_load (chk_load)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_wr_d  = is_wr_q;
      addr_d   = addr_q;
      data_d   = data_q;
      err_d    = err_q;
      load_d   = load_q;
      rdata_d  = rdata_q;
      shadow_d = shadow_q;

      unique case (state_q)
         ST_IDLE: begin
            if (host.req_valid) begin
               is_wr_d = host.req_write;
               addr_d  = host.req_addr;
               data_d  = host.req_data;
               err_d   = chk_err;
               load_d  = chk_load;
               rdata_d = 8'h00;
               // The control register is write-only: answer at once, no bus cycle
               if (!host.req_write && host.req_addr == PPI_PORT_CTRL) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_SETUP;
                  cnt_d   = SETUP_LD;
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               // Capture as late as possible in the strobe for data settling
               if (!is_wr_q) rdata_d = PD_in;
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            if (load_q) shadow_d = data_q;
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered outputs follow the state being entered
      bus_d       = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
      strobe_d    = (state_d == ST_STROBE);
      cs_d        = ~bus_d;
      rd_d        = ~(strobe_d && !is_wr_d);
      wr_d        = ~(strobe_d && is_wr_d);
      pd_oe_d     = bus_d && is_wr_d;
      pd_out_d    = (bus_d && is_wr_d) ? data_d : 8'h00;
      a_d         = bus_d ? addr_d : a_q;
      ready_d     = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      rsp_data_d  = (state_d == ST_RESP && !is_wr_d) ? rdata_d : 8'h00;
      rsp_err_d   = (state_d == ST_RESP) ? err_d : 1'b0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         is_wr_q     <= 1'b0;
         addr_q      <= 2'd0;
         data_q      <= 8'h00;
         err_q       <= 1'b0;
         load_q      <= 1'b0;
         rdata_q     <= 8'h00;
         shadow_q    <= CW_RESET;
         cs_q        <= 1'b1;
         rd_q        <= 1'b1;
         wr_q        <= 1'b1;
         a_q         <= 2'd0;
         pd_out_q    <= 8'h00;
         pd_oe_q     <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_wr_q     <= is_wr_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         err_q       <= err_d;
         load_q      <= load_d;
         rdata_q     <= rdata_d;
         shadow_q    <= shadow_d;
         cs_q        <= cs_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         a_q         <= a_d;
         pd_out_q    <= pd_out_d;
         pd_oe_q     <= pd_oe_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign host.req_ready = ready_q;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_data  = rsp_data_q;
   assign host.rsp_err   = rsp_err_q;
   assign busy           = busy_q;
   assign CS             = cs_q;
   assign RD             = rd_q;
   assign WR             = wr_q;
   assign A              = a_q;
   assign PD_out         = pd_out_q;
   assign PD_oe          = pd_oe_q;
   assign mode_shadow    = shadow_q;

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ppi_bus_sequencer
// Bench for the PPI bus sequencer: reset values, a table of directed
// transactions, back-to-back requests, random transactions against a
// transaction-level model, and reset in the middle of a strobe.
// ---------------------------------------------------------------------------
module tb_ppi_bus_sequencer;
   import ppi_pkg::*;

   localparam int TS   = 1;
   localparam int TST  = 2;
   localparam int TH   = 1;
   localparam int TBUS = TS + TST + TH;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy, cs, rd, wr, pd_oe;
   logic [1:0] a;
   logic [7:0] pd_out, pd_in, mode_shadow;

   always #5 clk = ~clk;

   ppi_bus_sequencer_if bus_if ();

   ppi_bus_sequencer #(
      .T_SETUP  (TS),
      .T_STROBE (TST),
      .T_HOLD   (TH),
      .CW_RESET (8'h9B)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .host        (bus_if),
      .busy        (busy),
      .CS          (cs),
      .RD          (rd),
      .WR          (wr),
      .A           (a),
      .PD_out      (pd_out),
      .PD_oe       (pd_oe),
      .PD_in       (pd_in),
      .mode_shadow (mode_shadow)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] shadow_m;

   typedef struct {
      logic       w;
      logic [1:0] addr;
      logic [7:0] data;
      logic [7:0] pdin;
      logic [7:0] exp_rdata;
      logic       exp_err;
      logic [7:0] exp_shadow;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Direction rules: bit = 1 means the port (half) is configured as input
   function automatic logic model_err(input logic [7:0] sh, input logic w, input logic [1:0] ad);
      case (ad)
         2'd0:    return w ? sh[4] : !sh[4];
         2'd1:    return w ? sh[1] : !sh[1];
         2'd2:    return w ? (sh[3] && sh[0]) : 1'b0;
         default: return !w;
      endcase
   endfunction

   // Called one time unit after a rising edge with the DUT idle; returns at
   // the same point in the first idle cycle after the response.
   task automatic do_txn(input logic w, input logic [1:0] ad, input logic [7:0] d,
                         input logic [7:0] pdin, input logic [7:0] exp_rdata,
                         input logic exp_err, input logic [7:0] exp_shadow);
      logic nobus;
      int   last;
      logic inbus, strobe;
      logic [6:0] e;
      nobus = !w && (ad == 2'd3);
      last  = nobus ? 1 : TBUS + 1;
      check("ready_before_req", bus_if.req_ready, 1);
      bus_if.req_valid = 1'b1;
      bus_if.req_write = w;
      bus_if.req_addr  = ad;
      bus_if.req_data  = d;
      pd_in            = pdin;
      @(posedge clk); #1;
      bus_if.req_valid = 1'b0;
      for (int k = 1; k <= last; k++) begin
         inbus  = !nobus && (k <= TBUS);
         strobe = inbus && (k > TS) && (k <= TS + TST);
         e = {!inbus, !(strobe && !w), !(strobe && w), inbus && w, 1'b1, 1'b0, (k == last)};
         check($sformatf("cs_rd_wr_oe_busy_rdy_rv w=%0d a=%0d k=%0d", w, ad, k),
               {cs, rd, wr, pd_oe, busy, bus_if.req_ready, bus_if.rsp_valid}, e);
         if (inbus) begin
            check($sformatf("addr k=%0d", k), a, ad);
            if (w) check($sformatf("pd_out k=%0d", k), pd_out, d);
         end
         if (k == last) begin
            check($sformatf("rsp_data w=%0d a=%0d", w, ad), bus_if.rsp_data, exp_rdata);
            check($sformatf("rsp_err w=%0d a=%0d", w, ad), bus_if.rsp_err, exp_err);
         end
         @(posedge clk); #1;
      end
      check("idle_busy_rdy_rv_cs", {busy, bus_if.req_ready, bus_if.rsp_valid, cs}, 4'b0101);
      check("mode_shadow", mode_shadow, exp_shadow);
      $display("txn w=%0d addr=%0d data=%02h pd_in=%02h -> exp rdata=%02h err=%0d shadow=%02h",
               w, ad, d, pdin, exp_rdata, exp_err, exp_shadow);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus_if.req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      shadow_m = 8'h9B;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic       w;
      logic [1:0] ad;
      logic [7:0] d, p, rdat;
      logic       er;

      tbl[0]  = '{1'b1, 2'd3, 8'h80, 8'h00, 8'h00, 1'b0, 8'h80};
      tbl[1]  = '{1'b1, 2'd0, 8'h55, 8'h00, 8'h00, 1'b0, 8'h80};
      tbl[2]  = '{1'b0, 2'd0, 8'h00, 8'hAA, 8'hAA, 1'b1, 8'h80};
      tbl[3]  = '{1'b1, 2'd3, 8'h9B, 8'h00, 8'h00, 1'b0, 8'h9B};
      tbl[4]  = '{1'b0, 2'd1, 8'h00, 8'h99, 8'h99, 1'b0, 8'h9B};
      tbl[5]  = '{1'b1, 2'd1, 8'h01, 8'h00, 8'h00, 1'b1, 8'h9B};
      tbl[6]  = '{1'b1, 2'd3, 8'h0F, 8'h00, 8'h00, 1'b0, 8'h9B};
      tbl[7]  = '{1'b0, 2'd3, 8'h00, 8'h5E, 8'h00, 1'b1, 8'h9B};
      tbl[8]  = '{1'b1, 2'd2, 8'h12, 8'h00, 8'h00, 1'b1, 8'h9B};
      tbl[9]  = '{1'b0, 2'd2, 8'h00, 8'h3C, 8'h3C, 1'b0, 8'h9B};
      tbl[10] = '{1'b1, 2'd3, 8'h88, 8'h00, 8'h00, 1'b0, 8'h88};
      tbl[11] = '{1'b1, 2'd2, 8'h77, 8'h00, 8'h00, 1'b0, 8'h88};
      tbl[12] = '{1'b0, 2'd1, 8'h00, 8'h11, 8'h11, 1'b1, 8'h88};
      tbl[13] = '{1'b1, 2'd1, 8'h22, 8'h00, 8'h00, 1'b0, 8'h88};

      // ---- reset values (checked while reset is held) ----
      rst = 1'b1;
      bus_if.req_valid = 1'b0;
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = 2'd0;
      bus_if.req_data  = 8'h00;
      pd_in            = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cs_rd_wr_oe", {cs, rd, wr, pd_oe}, 4'b1110);
      check("rst_a_pdout", {a, pd_out}, 10'h000);
      check("rst_rdy_rv_busy", {bus_if.req_ready, bus_if.rsp_valid, busy}, 3'b100);
      check("rst_rsp_data_err", {bus_if.rsp_data, bus_if.rsp_err}, 9'h000);
      check("rst_shadow", mode_shadow, 8'h9B);
      rst = 1'b0;
      @(posedge clk); #1;

      // ---- directed table ----
      for (int i = 0; i < 14; i++)
         do_txn(tbl[i].w, tbl[i].addr, tbl[i].data, tbl[i].pdin,
                tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_shadow);

      // ---- back-to-back: req_valid held high over three requests ----
      apply_reset();
      begin
         logic       qw [3];
         logic [1:0] qa [3];
         logic [7:0] qd [3];
         logic [7:0] qr [3];
         logic       qe [3];
         int idx, acc, rsps, runs, run_len;
         logic prev_cs, accept_now;
         qw[0] = 1'b0; qa[0] = 2'd1; qd[0] = 8'h00;
         qw[1] = 1'b1; qa[1] = 2'd0; qd[1] = 8'h5A;
         qw[2] = 1'b0; qa[2] = 2'd2; qd[2] = 8'h00;
         pd_in = 8'hC3;
         for (int i = 0; i < 3; i++) begin
            qe[i] = model_err(shadow_m, qw[i], qa[i]);
            qr[i] = qw[i] ? 8'h00 : pd_in;
         end
         idx = 0; acc = 0; rsps = 0; runs = 0; run_len = 0; prev_cs = 1'b1;
         bus_if.req_valid = 1'b1;
         bus_if.req_write = qw[0];
         bus_if.req_addr  = qa[0];
         bus_if.req_data  = qd[0];
         for (int cyc = 0; cyc < 60 && rsps < 3; cyc++) begin
            if (!rd && !wr) check("rd_wr_both_low", {rd, wr}, 2'b11);
            if (!cs) run_len++;
            if (prev_cs && !cs) runs++;
            if (!prev_cs && cs) check("cs_low_run_len", run_len, TBUS);
            if (cs) run_len = 0;
            prev_cs = cs;
            if (bus_if.rsp_valid) begin
               check($sformatf("b2b_rsp_data %0d", rsps), bus_if.rsp_data, qr[rsps]);
               check($sformatf("b2b_rsp_err %0d", rsps), bus_if.rsp_err, qe[rsps]);
               $display("b2b rsp %0d data=%02h err=%0d", rsps, bus_if.rsp_data, bus_if.rsp_err);
               rsps++;
            end
            accept_now = bus_if.req_valid && bus_if.req_ready;
            @(posedge clk); #1;
            if (accept_now) begin
               acc++;
               idx++;
               if (idx < 3) begin
                  bus_if.req_write = qw[idx];
                  bus_if.req_addr  = qa[idx];
                  bus_if.req_data  = qd[idx];
               end else begin
                  bus_if.req_valid = 1'b0;
               end
            end
         end
         bus_if.req_valid = 1'b0;
         check("b2b_responses", rsps, 3);
         check("b2b_accepts", acc, 3);
         check("b2b_cs_low_runs", runs, 3);
         @(posedge clk); #1;
      end

      // ---- random transactions against the model ----
      for (int i = 0; i < 40; i++) begin
         w  = 1'($urandom_range(0, 1));
         ad = 2'($urandom_range(0, 3));
         d  = 8'($urandom);
         p  = 8'($urandom);
         if (w && ad == 2'd3 && $urandom_range(0, 1) == 1) d[7] = 1'b1;
         er   = model_err(shadow_m, w, ad);
         rdat = (w || ad == 2'd3) ? 8'h00 : p;
         if (w && ad == 2'd3 && d[7]) shadow_m = d;
         do_txn(w, ad, d, p, rdat, er, shadow_m);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      // ---- reset during the strobe of a mode-set write ----
      bus_if.req_valid = 1'b1;
      bus_if.req_write = 1'b1;
      bus_if.req_addr  = 2'd3;
      bus_if.req_data  = 8'h80;
      @(posedge clk); #1;
      bus_if.req_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_wr_low_in_strobe", {cs, wr}, 2'b00);
      #2;
      rst = 1'b1;
      #1;
      check("abort_async_cs_rd_wr_oe", {cs, rd, wr, pd_oe}, 4'b1110);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("abort_no_rsp k=%0d", k), bus_if.rsp_valid, 0);
         @(posedge clk); #1;
      end
      check("abort_shadow", mode_shadow, 8'h9B);
      check("abort_rdy_busy", {bus_if.req_ready, busy}, 2'b10);
      $display("abort: reset in strobe, shadow=%02h", mode_shadow);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
